// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  // A frame is at most 12 bit times (start, 8 data, parity, stop, margin).
  localparam int TIMEOUT_BITS = 12;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set bit of mask at or above ptr, with wrap.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!any && mask[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    grant_onehot = any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte requesters,
// with packet lock and a Done watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  input  logic                 i_Timeout_Clr,
  output logic [IDX_W-1:0]     o_Owner,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               locked;
  logic [31:0]        counter;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [7:0]         pick_byte;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
    return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  // While a packet is open only the owner may be granted again.
  assign elig   = locked ? ((NUM_REQ'(1) << o_Owner) & i_Req_Valid) : i_Req_Valid;
  assign o_Busy = (state != IDLE) || locked;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask         (elig),
    .ptr          (rr_ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_byte = i_Req_Byte[8*i +: 8];
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      o_Req_Ready <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Owner     <= '0;
      o_Timeout   <= 1'b0;
      rr_ptr      <= '0;
      locked      <= 1'b0;
      counter     <= '0;
    end else begin
      o_Req_Ready <= '0;
      o_Tx_DV     <= 1'b0;
      // A timeout raised below in the same cycle overrides this clear.
      if (i_Timeout_Clr) o_Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && !i_Tx_Active) begin
            o_Tx_Byte   <= pick_byte;
            o_Owner     <= pick_idx;
            o_Req_Ready <= pick_onehot;
            o_Tx_DV     <= 1'b1;
            locked      <= ~i_Req_Last[pick_idx];
            if (i_Req_Last[pick_idx]) rr_ptr <= wrap_inc(pick_idx);
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          counter <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          counter <= counter + 32'd1;
          if (i_Tx_Done) begin
            state <= GAP;
          end else if (counter == 32'(TIMEOUT_CLKS - 1)) begin
            o_Timeout <= 1'b1;
            locked    <= 1'b0;
            rr_ptr    <= wrap_inc(o_Owner);
            state     <= IDLE;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester driver, transmitter model,
// grant monitor and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 12 * 87;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] b;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_byte;
  logic           tx_dv, tx_active, force_active, act_in, tx_done, tmo_clr;
  logic [7:0]     tx_byte;
  logic [1:0]     owner;
  logic           busy, tmo;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int dv_count = 0, done_count = 0;
  int last_dv_cyc = 0, last_done_cyc = 0, valid_rise_cyc = 0;
  int tx_delay_min = 5, tx_delay_max = 20, hang_cnt = 0;
  bit spur_en = 0, gap_chk = 0;
  int gap_from = 0;

  exp_t       exp_q[$];
  logic [8:0] src_q[N][$];
  logic [8:0] mdl_q[N][$];

  assign act_in = tx_active | force_active;

  uart_tx_arbiter dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_Req_Valid   (req_valid),
    .i_Req_Byte    (req_byte),
    .i_Req_Last    (req_last),
    .o_Req_Ready   (req_ready),
    .o_Tx_DV       (tx_dv),
    .o_Tx_Byte     (tx_byte),
    .i_Tx_Active   (act_in),
    .i_Tx_Done     (tx_done),
    .i_Timeout_Clr (tmo_clr),
    .o_Owner       (owner),
    .o_Busy        (busy),
    .o_Timeout     (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic bound_fail(input string name, input int max);
    checks++;
    errors++;
    $display("FAIL %s: no DUT event within %0d cycles (cycle %0d)", name, max, cyc);
  endtask

  function automatic bit src_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requesters: hold the head byte valid, advance the cycle after Ready.
  initial begin
    logic [N-1:0] rdy, prev;
    logic [8:0]   h;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      prev = req_valid;
      for (int k = 0; k < N; k++) begin
        if (rdy[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          h = src_q[k][0];
          req_valid[k]       = 1'b1;
          req_last[k]        = h[8];
          req_byte[8*k +: 8] = h[7:0];
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      if (prev == '0 && req_valid != '0) valid_rise_cyc = cyc;
    end
  end

  // Transmitter model; entered at posedge+1 of the cycle after DV.
  task automatic run_frame(input logic [7:0] b);
    int dly;
    if (hang_cnt > 0) begin
      hang_cnt--;
      return;
    end
    dly = int'($urandom_range(tx_delay_max, tx_delay_min));
    tx_active = 1'b1;
    for (int i = 1; i < dly; i++) begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_active = 1'b0;
        return;
      end
    end
    tx_done = 1'b1;
    last_done_cyc = cyc;
    done_count++;
    check("tx_byte_stable", tx_byte, b);
    @(posedge clk);
    #1;
    tx_done   = 1'b0;
    tx_active = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit dv_now;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_dv) begin
        b = tx_byte;
        @(posedge clk);
        #1;
        run_frame(b);
      end else if (spur_en && rst_n && $urandom_range(15, 0) == 0) begin
        // Stray Done while no frame is in flight must be ignored.
        @(posedge clk);
        #1;
        tx_done = 1'b1;
        @(negedge clk);
        dv_now = rst_n && tx_dv;
        b = tx_byte;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        if (dv_now) run_frame(b);
      end
    end
  end

  // Grant monitor: every DV pops one expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_dv) begin
        dv_count++;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_dv_owner", owner, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("grant_owner", owner, e.idx);
          check("grant_byte", tx_byte, e.b);
          check("grant_ready", req_ready, 32'(1) << e.idx);
          if (gap_chk && last_done_cyc > gap_from)
            check("done_to_dv_gap", cyc - last_done_cyc, 3);
        end
      end else if (rst_n && req_ready != '0) begin
        check("ready_without_dv", req_ready, 0);
      end
    end
  end

  task automatic push_exp(input int k, input logic [7:0] b);
    exp_q.push_back(exp_t'{idx: 2'(k), b: b});
  endtask

  task automatic wait_dv(input int start, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (dv_count > start) return;
    end
    bound_fail(name, max);
  endtask

  task automatic wait_drain(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && src_empty() && !busy && !tx_active && !tx_done) return;
    end
    bound_fail(name, max);
    exp_q.delete();
  endtask

  task automatic clear_stim();
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dvc, lcyc, f, d, mptr, k, np, len, remaining[N];
    logic [8:0] h;
    force_active = 1'b0;
    tmo_clr      = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_dv", tx_dv, 0);
    check("rst_byte", tx_byte, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte with a full-length frame
    tx_delay_min = 870;
    tx_delay_max = 870;
    dvc = dv_count;
    d   = done_count;
    src_q[0].push_back(9'h155);
    push_exp(0, 8'h55);
    wait_dv(dvc, 20, "single_dv");
    check("single_latency", last_dv_cyc, valid_rise_cyc + 1);
    for (int i = 0; i < 1000 && done_count == d; i++) @(negedge clk);
    if (done_count == d) bound_fail("single_done", 1000);
    @(negedge clk);
    check("single_busy_gap", busy, 1);
    @(negedge clk);
    check("single_busy_idle", busy, 0);
    check("single_byte_hold", tx_byte, 8'h55);
    tx_delay_min = 5;
    tx_delay_max = 20;
    wait_drain(100, "single_drain");

    // Round robin from pointer 0
    do_reset();
    src_q[0].push_back(9'h1A0);
    src_q[0].push_back(9'h1A0);
    src_q[1].push_back(9'h1A1);
    src_q[2].push_back(9'h1A2);
    src_q[3].push_back(9'h1A3);
    push_exp(0, 8'hA0);
    push_exp(1, 8'hA1);
    push_exp(2, 8'hA2);
    push_exp(3, 8'hA3);
    push_exp(0, 8'hA0);
    gap_from = cyc;
    gap_chk  = 1;
    wait_drain(400, "rr_drain");
    gap_chk  = 0;

    // Packet lock: pointer is 1 here
    src_q[1].push_back(9'h048);
    src_q[1].push_back(9'h049);
    src_q[1].push_back(9'h10A);
    src_q[0].push_back(9'h130);
    src_q[2].push_back(9'h132);
    push_exp(1, 8'h48);
    push_exp(1, 8'h49);
    push_exp(1, 8'h0A);
    push_exp(2, 8'h32);
    push_exp(0, 8'h30);
    wait_drain(400, "lock_drain");

    // Watchdog: first frame hangs, lock on Req1 must be released
    hang_cnt = 1;
    dvc = dv_count;
    src_q[1].push_back(9'h011);
    src_q[1].push_back(9'h112);
    src_q[3].push_back(9'h133);
    push_exp(1, 8'h11);
    push_exp(3, 8'h33);
    push_exp(1, 8'h12);
    wait_dv(dvc, 50, "wd_first_dv");
    lcyc = last_dv_cyc;
    for (int i = 0; i < T + 20 && !tmo; i++) @(negedge clk);
    // Flag rises TIMEOUT_CLKS cycles after the DV pulse has ended.
    check("wd_timeout_cycle", cyc, lcyc + T + 1);
    wait_dv(dvc + 1, 20, "wd_regrant_dv");
    check("wd_regrant_cycle", last_dv_cyc, lcyc + T + 2);
    wait_drain(400, "wd_drain");
    check("wd_sticky", tmo, 1);
    @(posedge clk);
    #1 tmo_clr = 1'b1;
    @(posedge clk);
    #1 tmo_clr = 1'b0;
    @(negedge clk);
    check("wd_cleared", tmo, 0);

    // Active gating
    force_active = 1'b1;
    dvc = dv_count;
    src_q[3].push_back(9'h177);
    push_exp(3, 8'h77);
    repeat (20) @(negedge clk);
    check("gate_no_dv", dv_count, dvc);
    @(posedge clk);
    #1 force_active = 1'b0;
    f = cyc;
    wait_dv(dvc, 20, "gate_dv");
    check("gate_dv_cycle", last_dv_cyc, f + 1);
    wait_drain(200, "gate_drain");

    // Reset in WAIT_DONE while a packet is open
    tx_delay_min = 200;
    tx_delay_max = 200;
    dvc = dv_count;
    src_q[0].push_back(9'h001);
    src_q[0].push_back(9'h102);
    push_exp(0, 8'h01);
    wait_dv(dvc, 20, "mid_rst_dv");
    repeat (10) @(negedge clk);
    check("mid_rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_dv", tx_dv, 0);
    check("mid_rst_byte", tx_byte, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", tmo, 0);
    clear_stim();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_delay_min = 5;
    tx_delay_max = 20;
    @(negedge clk);
    dvc = dv_count;
    src_q[2].push_back(9'h122);
    push_exp(2, 8'h22);
    wait_dv(dvc, 20, "post_rst_dv");
    check("post_rst_owner", owner, 2);
    wait_drain(200, "post_rst_drain");

    // Random packets: packet-level round robin from a known pointer
    do_reset();
    mptr = 0;
    spur_en = 1;
    tx_delay_min = 2;
    tx_delay_max = 25;
    for (int batch = 0; batch < 8; batch++) begin
      for (int r = 0; r < N; r++) begin
        remaining[r] = 0;
        mdl_q[r].delete();
        np = int'($urandom_range(2, 0));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(3, 1));
          for (int i = 0; i < len; i++) begin
            h = {(i == len - 1), 8'($urandom)};
            src_q[r].push_back(h);
            mdl_q[r].push_back(h);
          end
          remaining[r]++;
        end
      end
      forever begin
        k = -1;
        for (int off = 0; off < N && k < 0; off++)
          if (remaining[(mptr + off) % N] > 0) k = (mptr + off) % N;
        if (k < 0) break;
        do begin
          h = mdl_q[k].pop_front();
          push_exp(k, h[7:0]);
        end while (!h[8]);
        remaining[k]--;
        mptr = (k + 1) % N;
      end
      wait_drain(3000, "rand_drain");
    end
    spur_en = 0;
    check("rand_no_timeout", tmo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
